// File: rtl/mem_port_arbiter_if.sv
// One sram-like request/complete port: req+fields held until addr_ok, completion via data_ok.
// The master drives the request side and receives addr_ok/data_ok/rdata; the slave does the opposite.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between inst (i_port) and data (d_port) requesters.
// Latency: addr_ok same cycle as req, m_req next cycle; one transaction in flight, losers stall with req held.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_port_arbiter_if.slave      i_port,
  mem_port_arbiter_if.slave      d_port,
  mem_port_arbiter_if.master     m_port,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_i;
  logic              grant_d;
  logic              done;

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins alone or on a tie, unless it took the previous grant.
        if (d_port.req && (!i_port.req || last_grant_q == SIDE_I)) begin
          grant_d = 1'b1;
        end else if (i_port.req) begin
          grant_i = 1'b1;
        end
        if (grant_i || grant_d) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (m_port.addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_port.data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= SIDE_I;
      last_grant_q <= SIDE_I;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_i || grant_d) begin
        owner_q      <= grant_d;
        last_grant_q <= grant_d;
        wr_q         <= grant_d ? d_port.wr    : i_port.wr;
        size_q       <= grant_d ? d_port.size  : i_port.size;
        addr_q       <= grant_d ? d_port.addr  : i_port.addr;
        wdata_q      <= grant_d ? d_port.wdata : i_port.wdata;
      end
    end
  end

  assign i_port.addr_ok = grant_i;
  assign d_port.addr_ok = grant_d;

  // A data_ok outside WAIT is a downstream protocol violation and is dropped here.
  assign done           = (state_q == WAIT) && m_port.data_ok;
  assign i_port.data_ok = done && (owner_q == SIDE_I);
  assign d_port.data_ok = done && (owner_q == SIDE_D);
  assign i_port.rdata   = m_port.rdata;
  assign d_port.rdata   = m_port.rdata;

  assign m_port.req   = (state_q == REQ);
  assign m_port.wr    = wr_q;
  assign m_port.size  = size_q;
  assign m_port.addr  = addr_q;
  assign m_port.wdata = wdata_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors, downstream responder, decoupled monitor.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i_bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_port (i_bus),
    .d_port (d_bus),
    .m_port (m_bus),
    .busy   (busy)
  );

  typedef struct packed {
    logic        side;   // 0 = inst, 1 = data
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  typedef struct packed {
    logic        side;
    logic [31:0] rdata;
  } done_t;

  vec_t        vecs [0:14];
  vec_t        grant_q [$];
  done_t       done_q [$];
  logic [31:0] rsp_q [$];
  int          d_grant_cyc [$];

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   addr_lat = 0;
  int   data_lat = 0;
  int   grant_wait = -1;
  int   mreq_cnt = 0;
  int   dok_cnt = 0;
  logic busy_hist [0:4095];
  logic prev_mreq = 1'b0;
  logic have_cur = 1'b0;
  vec_t cur;
  done_t exp_done;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 4096) busy_hist[cyc] <= busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  task automatic expect_txn(input int idx, input logic [31:0] rdata);
    done_t e;
    e.side  = vecs[idx].side;
    e.rdata = rdata;
    grant_q.push_back(vecs[idx]);
    done_q.push_back(e);
    rsp_q.push_back(rdata);
  endtask

  // Presents vectors first..first+cnt-1 back to back; call at posedge+1.
  task automatic run_side(input int first, input int cnt);
    logic side;
    side = vecs[first].side;
    for (int k = 0; k < cnt; k++) begin
      vec_t v;
      int   w;
      logic got;
      v   = vecs[first + k];
      w   = 0;
      got = 1'b0;
      if (side) begin
        d_bus.req = 1'b1; d_bus.wr = v.wr; d_bus.size = v.size; d_bus.addr = v.addr; d_bus.wdata = v.wdata;
      end else begin
        i_bus.req = 1'b1; i_bus.wr = v.wr; i_bus.size = v.size; i_bus.addr = v.addr; i_bus.wdata = v.wdata;
      end
      while (!got && w < 100) begin
        @(negedge clk);
        got = side ? d_bus.addr_ok : i_bus.addr_ok;
        if (!got) w++;
      end
      if (!got) fail_now($sformatf("addr_ok_timeout_v%0d", first + k), "no addr_ok within 100 cycles");
      else begin
        grant_wait = w;
        if (side) d_grant_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    if (side) d_bus.req = 1'b0;
    else      i_bus.req = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((done_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("idle_timeout", "transactions still pending after 200 cycles");
    @(posedge clk); #1;
  endtask

  // Downstream responder: addr_ok addr_lat cycles into m_req, data_ok data_lat cycles after that.
  initial begin
    m_bus.addr_ok = 1'b0;
    m_bus.data_ok = 1'b0;
    m_bus.rdata   = '0;
    forever begin
      @(posedge clk); #1;
      if (m_bus.req === 1'b1) begin
        repeat (addr_lat) begin @(posedge clk); #1; end
        m_bus.addr_ok = 1'b1;
        @(posedge clk); #1;
        m_bus.addr_ok = 1'b0;
        repeat (data_lat) begin @(posedge clk); #1; end
        if (rsp_q.size() > 0) m_bus.rdata = rsp_q.pop_front();
        else begin
          fail_now("rsp_underflow", "downstream request with no response queued");
          m_bus.rdata = '0;
        end
        m_bus.data_ok = 1'b1;
        @(posedge clk); #1;
        m_bus.data_ok = 1'b0;
      end
    end
  end

  // Monitor: pops grant and completion expectations whenever the DUT presents them.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_mreq = 1'b0;
      end else begin
        if (i_bus.addr_ok || d_bus.addr_ok) begin
          if (i_bus.addr_ok && d_bus.addr_ok) fail_now("dual_addr_ok", "both addr_ok high");
          else if (grant_q.size() == 0) fail_now("unexpected_grant", "addr_ok with nothing expected");
          else begin
            cur      = grant_q.pop_front();
            have_cur = 1'b1;
            check("grant_side", 64'(d_bus.addr_ok), 64'(cur.side));
          end
        end
        if (m_bus.req) mreq_cnt++;
        if (m_bus.req && !prev_mreq && have_cur) begin
          check("m_wr_size", 64'({m_bus.wr, m_bus.size}), 64'({cur.wr, cur.size}));
          check("m_addr", 64'(m_bus.addr), 64'(cur.addr));
          check("m_wdata", 64'(m_bus.wdata), 64'(cur.wdata));
        end
        prev_mreq = m_bus.req;
        if (i_bus.data_ok || d_bus.data_ok) begin
          dok_cnt++;
          if (i_bus.data_ok && d_bus.data_ok) fail_now("dual_data_ok", "both data_ok high");
          else if (done_q.size() == 0) fail_now("unexpected_data_ok", "data_ok with nothing expected");
          else begin
            exp_done = done_q.pop_front();
            check("done_side", 64'(d_bus.data_ok), 64'(exp_done.side));
            check("rdata", 64'(d_bus.data_ok ? d_bus.rdata : i_bus.rdata), 64'(exp_done.rdata));
          end
        end
      end
    end
  end

  initial begin
    int low;
    int w;
    int dok_before;
    vecs[0]  = '{side:1'b0, wr:1'b0, size:2'd2, addr:32'h1FC00000, wdata:32'h0};
    vecs[1]  = '{side:1'b1, wr:1'b1, size:2'd2, addr:32'h00010004, wdata:32'hDEADBEEF};
    vecs[2]  = '{side:1'b0, wr:1'b0, size:2'd2, addr:32'h1FC00004, wdata:32'h0};
    vecs[3]  = '{side:1'b1, wr:1'b0, size:2'd2, addr:32'h00000100, wdata:32'h0};
    vecs[4]  = '{side:1'b1, wr:1'b1, size:2'd1, addr:32'h00000104, wdata:32'h0000CAFE};
    vecs[5]  = '{side:1'b1, wr:1'b0, size:2'd2, addr:32'h00000108, wdata:32'h0};
    vecs[6]  = '{side:1'b0, wr:1'b0, size:2'd2, addr:32'h1FC00008, wdata:32'h0};
    vecs[7]  = '{side:1'b0, wr:1'b0, size:2'd2, addr:32'h1FC0000C, wdata:32'h0};
    vecs[8]  = '{side:1'b0, wr:1'b0, size:2'd2, addr:32'h1FC00010, wdata:32'h0};
    vecs[9]  = '{side:1'b1, wr:1'b0, size:2'd2, addr:32'h00002000, wdata:32'h0};
    vecs[10] = '{side:1'b1, wr:1'b1, size:2'd2, addr:32'h00002004, wdata:32'h12345678};
    vecs[11] = '{side:1'b1, wr:1'b0, size:2'd2, addr:32'h00002008, wdata:32'h0};
    vecs[12] = '{side:1'b1, wr:1'b0, size:2'd2, addr:32'h00003000, wdata:32'h0};
    vecs[13] = '{side:1'b0, wr:1'b0, size:2'd2, addr:32'h1FC00020, wdata:32'h0};
    vecs[14] = '{side:1'b1, wr:1'b1, size:2'd0, addr:32'h00000003, wdata:32'h000000A5};

    i_bus.req = 1'b0; i_bus.wr = 1'b0; i_bus.size = 2'd0; i_bus.addr = '0; i_bus.wdata = '0;
    d_bus.req = 1'b0; d_bus.wr = 1'b0; d_bus.size = 2'd0; d_bus.addr = '0; d_bus.wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_req", 64'(m_bus.req), 64'h0);
    check("rst_m_fields", 64'({m_bus.wr, m_bus.size, m_bus.addr}), 64'h0);
    check("rst_m_wdata", 64'(m_bus.wdata), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_oks", 64'({i_bus.addr_ok, d_bus.addr_ok, i_bus.data_ok, d_bus.data_ok}), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single inst read, m_req held two cycles before addr_ok.
    addr_lat = 1; data_lat = 0; mreq_cnt = 0;
    expect_txn(0, 32'h3C080001);
    run_side(0, 1);
    check("t1_addr_ok_same_cycle", 64'(grant_wait), 64'd0);
    wait_idle();
    check("t1_m_req_cycles", 64'(mreq_cnt), 64'd2);

    // Simultaneous after reset: data first.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    addr_lat = 0; data_lat = 1;
    expect_txn(1, 32'h0);
    expect_txn(2, 32'h24090002);
    fork
      run_side(1, 1);
      run_side(2, 1);
    join
    wait_idle();

    // Continuous contention: D,I,D,I,D,I.
    addr_lat = 1; data_lat = 1;
    expect_txn(3, 32'h11111111);
    expect_txn(6, 32'h44444444);
    expect_txn(4, 32'h22222222);
    expect_txn(7, 32'h55555555);
    expect_txn(5, 32'h33333333);
    expect_txn(8, 32'h66666666);
    fork
      run_side(3, 3);
      run_side(6, 3);
    join
    wait_idle();

    // Back-to-back data with zero-wait downstream: a grant every 3 cycles.
    addr_lat = 0; data_lat = 0;
    d_grant_cyc.delete();
    expect_txn(9, 32'hAAAA0001);
    expect_txn(10, 32'hAAAA0002);
    expect_txn(11, 32'hAAAA0003);
    run_side(9, 3);
    wait_idle();
    if (d_grant_cyc.size() != 3) fail_now("b2b_grants", $sformatf("saw %0d grants, need 3", d_grant_cyc.size()));
    else begin
      check("b2b_gap1", 64'(d_grant_cyc[1] - d_grant_cyc[0]), 64'd3);
      check("b2b_gap2", 64'(d_grant_cyc[2] - d_grant_cyc[1]), 64'd3);
      low = 0;
      for (int c = d_grant_cyc[0]; c <= d_grant_cyc[2]; c++) if (!busy_hist[c]) low++;
      check("b2b_idle_cycles", 64'(low), 64'd3);
    end

    // Reset during WAIT: transaction dropped, no data_ok.
    addr_lat = 0; data_lat = 4;
    grant_q.push_back(vecs[12]);
    rsp_q.push_back(32'hBAD0BAD0);
    run_side(12, 1);
    w = 0;
    while (!(busy && !m_bus.req) && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) fail_now("t5_reach_wait", "never reached WAIT");
    dok_before = dok_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_m_req", 64'(m_bus.req), 64'h0);
    check("t5_busy", 64'(busy), 64'h0);
    repeat (8) @(negedge clk);
    check("t5_no_data_ok", 64'(dok_cnt - dok_before), 64'd0);
    check("t5_rsp_consumed", 64'(rsp_q.size()), 64'd0);
    addr_lat = 0; data_lat = 0;
    expect_txn(13, 32'h77777777);
    @(posedge clk); #1;
    run_side(13, 1);
    check("t5_next_accept", 64'(grant_wait), 64'd0);
    wait_idle();

    // Byte store at an odd address passes through untouched.
    expect_txn(14, 32'h0);
    run_side(14, 1);
    wait_idle();

    check("end_grants_left", 64'(grant_q.size()), 64'd0);
    check("end_done_left", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
